// File: rtl/nes_pkg.sv
// ---------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the NES controller poller: FSM state encoding,
// button bit positions within the 8-bit button word, and a helper that
// sizes the half-period/latch timing counter.
// ---------------------------------------------------------------------------
package nes_pkg;

  localparam int NES_NUM_BTNS = 8;

  // Bit positions in the button word, in the order the pad shifts them out.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LO,
    HI,
    DONE
  } nes_state_e;

  // The longest interval the timing counter must hold is the latch pulse,
  // 2*half_cyc cycles, loaded as 2*half_cyc-1.
  function automatic int tick_width(input int half_cyc);
    return $clog2(2 * half_cyc);
  endfunction

endpackage : nes_pkg

// File: rtl/nes_tick_gen.sv
// ---------------------------------------------------------------------------
// nes_tick_gen
// Loadable down-counter that times the latch pulse and each nes_clk
// half-period. Loading N makes tc rise after N+1 cycles in the loaded state,
// so a segment of L cycles is started by loading L-1.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   load      load load_val this cycle (takes priority over counting)
//   load_val  value to load
//   tc        terminal count: counter is zero
// ---------------------------------------------------------------------------
module nes_tick_gen #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule : nes_tick_gen

// File: rtl/nes_poll_ctrl.sv
// ---------------------------------------------------------------------------
// nes_poll_ctrl
// Polls an NES pad shift register: strobes nes_latch, clocks out eight
// button bits on nes_clk, and presents the active-high button word with a
// one-cycle valid pulse. Frames start automatically every POLL_CYC idle
// cycles or immediately on poll_req.
//
// Frame timing from LATCH entry: 2*HALF_CYC latch cycles, then per bit
// HALF_CYC cycles low and HALF_CYC cycles high, then one DONE cycle:
// 18*HALF_CYC+1 cycles in total. Data is sampled on the last low cycle of
// each bit, i.e. just before the rising nes_clk edge shifts the pad.
//
// All outputs are registered and change together with the state register,
// so nes_latch/nes_clk are glitch-free and never high at once.
//
// Optional build macro: NES_POLL_DEBOUNCE_EN -- when defined, a frame only
// updates buttons (and pulses valid) if it matches the previous frame.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   poll_req    one-cycle request for an immediate poll (ignored while busy)
//   nes_data_n  serial button data from the pad, active-low
//   nes_latch   latch strobe to the pad, active-high
//   nes_clk     shift clock to the pad, idle low
//   buttons     [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   valid       one-cycle pulse when buttons updates
//   busy        high while a frame is in progress
// ---------------------------------------------------------------------------
module nes_poll_ctrl
  import nes_pkg::*;
#(
  parameter int HALF_CYC = 6,
  parameter int POLL_CYC = 20000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    poll_req,
  input  logic                    nes_data_n,
  output logic                    nes_latch,
  output logic                    nes_clk,
  output logic [NES_NUM_BTNS-1:0] buttons,
  output logic                    valid,
  output logic                    busy
);

  localparam int TW = tick_width(HALF_CYC);
  localparam int PW = $clog2(POLL_CYC);
  localparam int IW = $clog2(NES_NUM_BTNS);

  localparam logic [TW-1:0] LATCH_LOAD = TW'(2 * HALF_CYC - 1);
  localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_CYC - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [IW-1:0] LAST_BIT   = IW'(BTN_RIGHT);

  nes_state_e              state;
  logic [PW-1:0]           poll_cnt;
  logic [IW-1:0]           bit_idx;
  logic [NES_NUM_BTNS-1:0] shift_q;
`ifdef NES_POLL_DEBOUNCE_EN
  logic [NES_NUM_BTNS-1:0] prev_q;
`endif

  logic          start;
  logic          tick_load;
  logic [TW-1:0] tick_val;
  logic          tick_tc;

  // A frame starts from IDLE on terminal count or request; both together
  // still produce a single start since only one transition can occur.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    start     = 1'b0;
    tick_load = 1'b0;
    tick_val  = HALF_LOAD;
    if (state == IDLE) begin
      start = poll_req || (poll_cnt == POLL_LAST);
    end
    if (start) begin
      tick_load = 1'b1;
      tick_val  = LATCH_LOAD;
    end else if ((state == LATCH || state == LO || state == HI) && tick_tc) begin
      tick_load = 1'b1;
    end
  end

  nes_tick_gen #(
    .W (TW)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (tick_load),
    .load_val (tick_val),
    .tc       (tick_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      poll_cnt  <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      buttons   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
`ifdef NES_POLL_DEBOUNCE_EN
      prev_q    <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LATCH;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
            poll_cnt  <= '0;
          end else begin
            poll_cnt  <= poll_cnt + PW'(1);
          end
        end
        LATCH: begin
          if (tick_tc) begin
            state     <= LO;
            nes_latch <= 1'b0;
            bit_idx   <= '0;
          end
        end
        LO: begin
          if (tick_tc) begin
            shift_q[bit_idx] <= ~nes_data_n;
            state            <= HI;
            nes_clk          <= 1'b1;
          end
        end
        HI: begin
          if (tick_tc) begin
            nes_clk <= 1'b0;
            if (bit_idx == LAST_BIT) begin
              state <= DONE;
              // Buttons and valid are loaded on DONE entry so they appear
              // during the DONE cycle, aligned with the state.
`ifdef NES_POLL_DEBOUNCE_EN
              if (shift_q == prev_q) begin
                buttons <= shift_q;
                valid   <= 1'b1;
              end
              prev_q <= shift_q;
`else
              buttons <= shift_q;
              valid   <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + IW'(1);
              state   <= LO;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : nes_poll_ctrl

// File: doc/nes_poll_ctrl.md
NES_POLL_CTRL -- requirements
Module: nes_poll_ctrl

Interface
REQ-001 SHALL have parameter HALF_CYC, default 6, meaning clk cycles per nes_clk half-period (legal 1..255).
REQ-002 SHALL have parameter POLL_CYC, default 20000, meaning clk cycles between automatic poll starts (legal > 20*HALF_CYC).
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port poll_req  input  1  one-cycle request for an immediate poll.
REQ-006 SHALL have port nes_data_n  input  1  serial button data from the pad shifter, active-low.
REQ-007 SHALL have port nes_latch  output  1  latch strobe to the pad shifter, active-high.
REQ-008 SHALL have port nes_clk  output  1  shift clock to the pad shifter, idle low.
REQ-009 SHALL have port buttons  output  8  active-high state: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
REQ-010 SHALL have port valid  output  1  one-cycle pulse when buttons updates.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL implement FSM states IDLE, LATCH, LO, HI, DONE.
REQ-013 IDLE: free-running poll counter counts 0..POLL_CYC-1; at POLL_CYC-1 or on poll_req, SHALL go to LATCH next cycle and clear the counter.
REQ-014 LATCH: nes_latch=1 for exactly 2*HALF_CYC cycles, then LO with bit index 0.
REQ-015 LO: nes_clk=0 for HALF_CYC cycles; on the last LO cycle SHALL capture ~nes_data_n into shift bit[index].
REQ-016 HI: nes_clk=1 for HALF_CYC cycles; afterwards index+1 and LO if index<7, else DONE.
REQ-017 DONE: one cycle; buttons loaded from shift register (subject to REQ-024), valid=1, then IDLE.
REQ-018 Frame length SHALL be 18*HALF_CYC+1 cycles from LATCH entry to return to IDLE; busy=1 in all states except IDLE.
REQ-019 poll_req while busy=1 SHALL be ignored (not queued); auto-poll counter SHALL be held at 0 while busy.
REQ-020 poll_req coincident with counter terminal count SHALL start exactly one frame.
REQ-021 nes_latch and nes_clk SHALL be registered outputs, never high simultaneously, glitch-free.

Reset
REQ-022 On reset assertion, immediately: state=IDLE, nes_latch=0, nes_clk=0, buttons=8'h00, valid=0, busy=0, counters and shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame with no valid pulse; the first frame after release starts per REQ-013.

Configuration
REQ-024 With macro NES_POLL_DEBOUNCE_EN defined, DONE SHALL load buttons and pulse valid only if the captured frame equals the previously captured frame (previous-frame register resets to 0); otherwise only the previous-frame register updates.
REQ-025 Without NES_POLL_DEBOUNCE_EN, every DONE SHALL load buttons and pulse valid.

Structure
REQ-026 Shared package nes_pkg SHALL hold the FSM state enum, button index constants (BTN_A..BTN_RIGHT) and NES_NUM_BTNS=8.
REQ-027 Half-period/latch timing counter SHALL be sub-module nes_tick_gen (load, count, terminal-count output); FSM and shift register stay in nes_poll_ctrl.

Verification (HALF_CYC=4, POLL_CYC=200 unless stated)
REQ-028 Pad model drives A and Start pressed (data_n low for bits 0,3); poll_req -> nes_latch high 8 cycles, 8 nes_clk pulses of 4 high/4 low, valid at cycle 72 after LATCH entry, buttons=8'h09.
REQ-029 No poll_req -> frames start every 200 idle cycles; each frame 73 cycles; busy matches.
REQ-030 poll_req pulsed at cycles 10 and 40 of a frame -> both ignored, exactly one valid.
REQ-031 reset asserted during HI of bit 4 -> outputs zero same cycle, no valid; after release next auto frame returns correct buttons.
REQ-032 NES_POLL_DEBOUNCE_EN defined, frames read 8'h10, 8'h10, 8'h20, 8'h20 -> valid on frames 2 and 4 only, buttons 8'h10 then 8'h20; undefined -> valid every frame.
